// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 master port between the fetch (read-only) and data (read/write)
// requesters. Runs one single-beat transaction at a time and returns a one-cycle ack.
module axi_mem_arbiter #(
    parameter int          DATA_PRIO = 0,
    parameter logic [31:0] RST_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        busy,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_AW_W, WR_RESP, ACK} state_t;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t state;
    logic   owner, last_grant, aw_done, w_done;
    logic   grant, aw_hs, w_hs;

    // On a tie the data port wins if it has fixed priority or fetch was served last.
    always_comb begin
        grant = PORT_I;
        if (d_req && (!i_req || DATA_PRIO != 0 || last_grant == PORT_I))
            grant = PORT_D;
    end

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= PORT_I;
            last_grant    <= PORT_D;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            busy          <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            m_axi_awaddr  <= RST_ADDR;
            m_axi_araddr  <= RST_ADDR;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner      <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        if (grant == PORT_D && d_we) begin
                            m_axi_awaddr  <= d_addr;
                            m_axi_wdata   <= d_wdata;
                            m_axi_wstrb   <= d_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= WR_AW_W;
                        end else begin
                            m_axi_araddr  <= (grant == PORT_D) ? d_addr : i_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (owner == PORT_D) begin
                            d_rdata <= m_axi_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= m_axi_rdata;
                            i_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end
                end
                WR_AW_W: begin
                    // AW and W complete independently, possibly in the same cycle.
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        d_ack        <= 1'b1;
                        state        <= ACK;
                    end
                end
                ACK: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench: drivers push expected responses, a monitor pops them on each ack,
// and a slave model checks write contents and AXI hold rules.
module tb_axi_mem_arbiter;
    localparam logic [31:0] RA = 32'h1000_0000;
    localparam int M_RAND = 0, M_CONST = 1, M_MAN = 2;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] rdata;

    logic        i_ack, d_ack, busy, awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] i_rdata, d_rdata, awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        p_i_ack, p_d_ack, p_busy, p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
    logic [31:0] p_i_rdata, p_d_rdata, p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    axi_mem_arbiter #(.DATA_PRIO(0), .RST_ADDR(RA)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Fixed-priority instance; only its ack ordering is checked, with an always-ready slave.
    axi_mem_arbiter #(.DATA_PRIO(1), .RST_ADDR(RA)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(p_i_ack), .i_rdata(p_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(p_d_ack), .d_rdata(p_d_rdata), .busy(p_busy),
        .m_axi_awaddr(p_awaddr), .m_axi_awvalid(p_awvalid), .m_axi_awready(awready),
        .m_axi_wdata(p_wdata), .m_axi_wstrb(p_wstrb), .m_axi_wvalid(p_wvalid), .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bready(p_bready),
        .m_axi_araddr(p_araddr), .m_axi_arvalid(p_arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(p_rready)
    );

    int          checks = 0, errors = 0;
    int          mode, pct;
    logic        man_ar, man_aw, man_w, man_r, man_b;
    logic [31:0] iq[$];
    req_t        dq[$], wq[$];
    logic [1:0]  a0[1:40], a1[1:40];
    logic        b0[1:40];

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Waits for an ack from u0 on the chosen port and drops that request.
    task automatic wait_ack(input bit data_port, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(data_port ? d_ack : i_ack) && k < 300);
        if (k >= 300) chk({name, "_timeout"}, data_port ? d_ack : i_ack, 1);
        if (data_port) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    task automatic fetch_drv(input int n);
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1;
            i_addr = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
            i_req  = 1'b1;
            iq.push_back(f(i_addr));
            wait_ack(1'b0, "rand_fetch");
        end
    endtask

    task automatic data_drv(input int n);
        req_t e;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1;
            e.we    = ($urandom_range(0, 1) == 1);
            e.addr  = 32'h0000_2000 + ($urandom_range(0, 255) << 2);
            e.wdata = $urandom;
            e.strb  = 4'($urandom_range(1, 15));
            d_we = e.we; d_addr = e.addr; d_wdata = e.wdata; d_wstrb = e.strb;
            d_req = 1'b1;
            dq.push_back(e);
            if (e.we) wq.push_back(e);
            wait_ack(1'b1, "rand_data");
        end
    endtask

    // Monitor for u0: every ack pops the scoreboard of its own port.
    initial begin
        logic [31:0] last_dr;
        logic        prev_i, prev_d;
        req_t        e;
        last_dr = '0; prev_i = 1'b0; prev_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_dr = '0; prev_i = 1'b0; prev_d = 1'b0;
                continue;
            end
            if (i_ack || d_ack) chk("ack_overlap", i_ack & d_ack, 0);
            if (i_ack) begin
                chk("i_ack_pulse", prev_i, 0);
                chk("i_ack_expected", iq.size() > 0, 1);
                if (iq.size() > 0) chk("i_rdata", i_rdata, iq.pop_front());
            end
            if (d_ack) begin
                chk("d_ack_pulse", prev_d, 0);
                chk("d_ack_expected", dq.size() > 0, 1);
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    if (e.we) chk("d_rdata_hold_on_write", d_rdata, last_dr);
                    else begin
                        chk("d_rdata", d_rdata, f(e.addr));
                        last_dr = f(e.addr);
                    end
                end
            end
            prev_i = i_ack;
            prev_d = d_ack;
        end
    end

    // Slave model for u0: inputs change only at negedge, so a valid/ready pair seen
    // here is exactly the handshake taken at the next posedge.
    initial begin
        logic        rd_pend, b_pend, aw_got, w_got, ar_wait, aw_wait, w_wait;
        int          rd_cnt, b_cnt;
        logic [31:0] rd_a, got_a, got_d, ar_a, aw_a, w_d;
        logic [3:0]  got_s, w_s;
        req_t        e;
        {arready, awready, wready, rvalid, bvalid} = '0;
        rdata = '0;
        {rd_pend, b_pend, aw_got, w_got, ar_wait, aw_wait, w_wait} = '0;
        rd_cnt = 0; b_cnt = 0;
        rd_a = '0; got_a = '0; got_d = '0; got_s = '0; ar_a = '0; aw_a = '0; w_d = '0; w_s = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {arready, awready, wready, rvalid, bvalid} = '0;
                {rd_pend, b_pend, aw_got, w_got, ar_wait, aw_wait, w_wait} = '0;
                continue;
            end
            if (ar_wait) chk("ar_hold", {arvalid, araddr}, {1'b1, ar_a});
            if (aw_wait) chk("aw_hold", {awvalid, awaddr}, {1'b1, aw_a});
            if (w_wait)  chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, w_d, w_s});
            case (mode)
                M_CONST: {arready, awready, wready, rvalid, bvalid} = '1;
                M_MAN: begin
                    arready = man_ar; awready = man_aw; wready = man_w;
                    rvalid  = man_r;  bvalid  = man_b;
                end
                default: begin
                    rvalid = 1'b0;
                    if (rd_pend) begin
                        if (rd_cnt == 0) rvalid = 1'b1;
                        else rd_cnt--;
                    end
                    bvalid = 1'b0;
                    if (b_pend) begin
                        if (b_cnt == 0) bvalid = 1'b1;
                        else b_cnt--;
                    end
                    arready = ($urandom_range(0, 99) < pct);
                    awready = ($urandom_range(0, 99) < pct);
                    wready  = ($urandom_range(0, 99) < pct);
                end
            endcase
            rdata = (mode == M_RAND) ? f(rd_a) : f(araddr);
            if (rvalid && rready) rd_pend = 1'b0;
            if (arvalid && arready) begin
                rd_pend = 1'b1; rd_a = araddr; rd_cnt = $urandom_range(0, 3);
            end
            if (awvalid && awready) begin aw_got = 1'b1; got_a = awaddr; end
            if (wvalid && wready) begin w_got = 1'b1; got_d = wdata; got_s = wstrb; end
            if (mode == M_RAND && aw_got && w_got && !b_pend) begin
                b_pend = 1'b1; b_cnt = $urandom_range(0, 3);
            end
            if (bvalid && bready) begin
                chk("b_after_aw_w", aw_got && w_got, 1);
                chk("wq_nonempty", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("awaddr", got_a, e.addr);
                    chk("wdata", got_d, e.wdata);
                    chk("wstrb", got_s, e.strb);
                end
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0;
            end
            ar_wait = arvalid && !arready; ar_a = araddr;
            aw_wait = awvalid && !awready; aw_a = awaddr;
            w_wait  = wvalid && !wready;   w_d = wdata; w_s = wstrb;
        end
    end

    initial begin
        int   k, ar_k, ack_k, n_ack, d_seen;
        req_t e;
        rst_n = 1'b0; mode = M_MAN; pct = 60;
        {man_ar, man_aw, man_w, man_r, man_b} = '0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_handshakes", {arvalid, awvalid, wvalid, rready, bready, i_ack, d_ack}, 0);
        chk("rst_araddr", araddr, RA);
        chk("rst_awaddr", awaddr, RA);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_wdata_wstrb", {wdata, wstrb}, 0);
        rst_n = 1'b1;

        // Fetch read, always-ready slave: request sampled at the 2nd negedge's posedge.
        mode = M_CONST;
        @(posedge clk); #1;
        i_addr = 32'h100; i_req = 1'b1; iq.push_back(f(32'h100));
        ar_k = -1; ack_k = -1; n_ack = 0; d_seen = 0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (arvalid && ar_k < 0) ar_k = j;
            if (i_ack) begin
                n_ack++;
                if (ack_k < 0) ack_k = j;
                i_req = 1'b0;
            end
            if (d_ack) d_seen = 1;
        end
        chk("fetch_arvalid_cycle", ar_k, 2);
        chk("fetch_ack_cycle", ack_k, 4);
        chk("fetch_single_ack", n_ack, 1);
        chk("fetch_no_d_ack", d_seen, 0);

        // Data write with W accepted three cycles after AW.
        mode = M_MAN; man_aw = 1'b1;
        @(posedge clk); #1;
        e.we = 1'b1; e.addr = 32'h2004; e.wdata = 32'h0000_AB00; e.strb = 4'b0010;
        d_we = 1'b1; d_addr = e.addr; d_wdata = e.wdata; d_wstrb = e.strb; d_req = 1'b1;
        dq.push_back(e); wq.push_back(e);
        @(negedge clk);
        @(negedge clk); chk("wr_start", {awvalid, wvalid, bready}, 3'b110);
        @(negedge clk); chk("wr_aw_done", {awvalid, wvalid, bready}, 3'b010);
        @(negedge clk); chk("wr_w_wait1", {awvalid, wvalid, bready}, 3'b010);
        @(posedge clk); #1; man_w = 1'b1;
        @(negedge clk); chk("wr_w_wait2", {awvalid, wvalid, bready}, 3'b010);
        @(negedge clk); chk("wr_bready", {awvalid, wvalid, bready, d_ack}, 4'b0010);
        @(posedge clk); #1; man_b = 1'b1;
        @(negedge clk); chk("wr_b_wait", {bready, d_ack}, 2'b10);
        @(negedge clk); chk("wr_ack", {bready, d_ack}, 2'b01); d_req = 1'b0;
        @(negedge clk); chk("wr_ack_once", {d_ack, busy}, 2'b00);
        @(posedge clk); #1; {man_ar, man_aw, man_w, man_r, man_b} = '0;

        // Read with AR stalled, then R stalled.
        i_addr = 32'h340; i_req = 1'b1; iq.push_back(f(32'h340));
        @(negedge clk);
        repeat (5) begin
            @(negedge clk); chk("stall_ar", {arvalid, araddr, rready}, {1'b1, 32'h340, 1'b0});
        end
        @(posedge clk); #1; man_ar = 1'b1;
        @(negedge clk); chk("stall_ar_hs", {arvalid, rready}, 2'b10);
        @(posedge clk); #1; man_ar = 1'b0;
        repeat (4) begin
            @(negedge clk); chk("stall_r", {arvalid, rready, i_ack}, 3'b010);
        end
        @(posedge clk); #1; man_r = 1'b1;
        @(negedge clk); chk("stall_r_hs", {rready, i_ack}, 2'b10);
        @(posedge clk); #1; man_r = 1'b0;
        @(negedge clk); chk("stall_ack", {rready, i_ack}, 2'b01); i_req = 1'b0;

        // Tie from reset: u0 alternates fetch/data, u1 always serves data.
        rst_n = 1'b0; mode = M_CONST;
        iq.delete(); dq.delete(); wq.delete();
        i_addr = 32'h100; d_addr = 32'h2000; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
        e.we = 1'b0; e.addr = 32'h2000; e.wdata = '0; e.strb = '0;
        for (int j = 0; j < 30; j++) begin
            iq.push_back(f(32'h100));
            dq.push_back(e);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            a0[j] = {i_ack, d_ack}; a1[j] = {p_i_ack, p_d_ack}; b0[j] = busy;
        end
        d_req = 1'b0;
        // Acks land every 4th cycle (ACK, IDLE, address, data) starting at cycle 3.
        for (int j = 1; j <= 40; j++) begin
            chk("tie_rr_ack", a0[j], (j % 4 != 3) ? 2'b00 : ((((j - 3) / 4) % 2 == 0) ? 2'b10 : 2'b01));
            chk("tie_rr_busy", b0[j], (j % 4 == 0) ? 1'b0 : 1'b1);
            chk("tie_prio_ack", a1[j], (j % 4 == 3) ? 2'b01 : 2'b00);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!p_i_ack && k < 20);
        chk("prio_fetch_after_drop", k, 3);
        i_req = 1'b0;

        // Reset while waiting in RD_DATA; the still-pending fetch is then served.
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        iq.delete(); dq.delete(); wq.delete();
        @(negedge clk); rst_n = 1'b1;
        mode = M_MAN; man_ar = 1'b1;
        @(posedge clk); #1;
        i_addr = 32'h480; i_req = 1'b1; iq.push_back(f(32'h480));
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("pre_reset_rd_data", {rready, busy}, 2'b11);
        #2; rst_n = 1'b0;
        #1; chk("async_reset", {arvalid, awvalid, wvalid, rready, bready, i_ack, d_ack, busy}, 0);
        @(negedge clk); rst_n = 1'b1; mode = M_CONST; man_ar = 1'b0;
        wait_ack(1'b0, "post_reset");

        // Randomized traffic against a randomly stalling slave.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mode = M_RAND;
        fork
            fetch_drv(40);
            data_drv(40);
        join
        repeat (5) @(negedge clk);
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        chk("wq_drained", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
